// File: rtl/ahbl_sram_ctrl.sv
// SRAM control stage behind the AHB-Lite slave: one request in, one SRAM access,
// one-cycle ack out, with optional wait states ahead of each access.
//
// state  | meaning
// IDLE   | waiting for a request pulse; capture address/data/size on request
// WAIT   | counting down inserted wait states before the RAM access
// ACCESS | RAM strobe (write or read) driven for one cycle
// RDCAP  | RAM read data arrives and is registered onto sramahb_rdata
// ACK    | one-cycle completion pulse to the slave interface
module ahbl_sram_ctrl #(
   parameter int AHB_DWIDTH  = 32,
   parameter int RAM_AWIDTH  = 14,
   parameter int WAIT_STATES = 0
) (
   input  logic                  HCLK,
   input  logic                  HRESETN,
   input  logic                  ahbsram_req,
   input  logic                  ahbsram_write,
   input  logic [AHB_DWIDTH-1:0] ahbsram_wdata,
   input  logic [2:0]            ahbsram_size,
   input  logic [19:0]           ahbsram_addr,
   output logic                  sramahb_ack,
   output logic [AHB_DWIDTH-1:0] sramahb_rdata,
   output logic                  BUSY,
   output logic [RAM_AWIDTH-1:0] ram_addr,
   output logic [AHB_DWIDTH-1:0] ram_wdata,
   output logic [3:0]            ram_ben,
   output logic                  ram_wen,
   output logic                  ram_ren,
   input  logic [AHB_DWIDTH-1:0] ram_rdata
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACCESS,
      ST_RDCAP,
      ST_ACK
   } state_t;

   localparam logic [2:0] WS_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

   state_t     state, state_nxt;
   logic [2:0] wait_cnt;
   logic       wr_q;
   logic       capture;
   logic       access_wr;
   logic [3:0] ben_nxt;
   logic       unused_addr_hi;

   // Upper address bits alias onto the RAM; they are deliberately dropped.
   assign unused_addr_hi = ^ahbsram_addr[19:RAM_AWIDTH+2];

   assign capture   = (state == ST_IDLE) && ahbsram_req;
   assign access_wr = capture ? ahbsram_write : wr_q;

   always_comb begin
      ben_nxt = 4'b1111;
      if (ahbsram_size == 3'd0) begin
         ben_nxt = 4'b0001 << ahbsram_addr[1:0];
      end else if (ahbsram_size == 3'd1) begin
         ben_nxt = ahbsram_addr[1] ? 4'b1100 : 4'b0011;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (ahbsram_req) begin
               state_nxt = (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
            end
         end
         ST_WAIT: begin
            if (wait_cnt == 3'd0) begin
               state_nxt = ST_ACCESS;
            end
         end
         ST_ACCESS: state_nxt = wr_q ? ST_ACK : ST_RDCAP;
         ST_RDCAP:  state_nxt = ST_ACK;
         ST_ACK:    state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Strobes, ack and BUSY are registered from the next state so they line up
   // with the state they describe and come straight out of flops.
   always_ff @(posedge HCLK or negedge HRESETN) begin
      if (!HRESETN) begin
         state         <= ST_IDLE;
         wait_cnt      <= 3'd0;
         wr_q          <= 1'b0;
         ram_addr      <= '0;
         ram_wdata     <= '0;
         ram_ben       <= 4'b0000;
         ram_wen       <= 1'b0;
         ram_ren       <= 1'b0;
         sramahb_ack   <= 1'b0;
         sramahb_rdata <= '0;
         BUSY          <= 1'b0;
      end else begin
         state <= state_nxt;
         if (capture) begin
            wr_q      <= ahbsram_write;
            ram_wdata <= ahbsram_wdata;
            ram_addr  <= ahbsram_addr[RAM_AWIDTH+1:2];
            ram_ben   <= ben_nxt;
            wait_cnt  <= WS_LOAD;
         end else if ((state == ST_WAIT) && (wait_cnt != 3'd0)) begin
            wait_cnt <= wait_cnt - 3'd1;
         end
         ram_wen     <= (state_nxt == ST_ACCESS) && access_wr;
         ram_ren     <= (state_nxt == ST_ACCESS) && !access_wr;
         sramahb_ack <= (state_nxt == ST_ACK);
         BUSY        <= (state_nxt != ST_IDLE);
         if (state == ST_RDCAP) begin
            sramahb_rdata <= ram_rdata;
         end
      end
   end

endmodule

// File: tb/tb_ahbl_sram_ctrl.sv
// Directed bench for ahbl_sram_ctrl: one instance without wait states and one
// with three, each backed by a behavioural one-cycle-latency SRAM.
module tb_ahbl_sram_ctrl;

   logic        HCLK = 1'b0;
   logic        HRESETN = 1'b0;
   logic        req0 = 1'b0, req3 = 1'b0;
   logic        ahb_write = 1'b0;
   logic [31:0] ahb_wdata = '0;
   logic [2:0]  ahb_size = '0;
   logic [19:0] ahb_addr = '0;

   logic        ack0, busy0, wen0, ren0;
   logic [31:0] rdata0, rwdata0, mrdata0;
   logic [13:0] raddr0;
   logic [3:0]  ben0;
   logic        ack3, busy3, wen3, ren3;
   logic [31:0] rdata3, rwdata3, mrdata3;
   logic [13:0] raddr3;
   logic [3:0]  ben3;

   logic [31:0] mem0 [0:16383];
   logic [31:0] mem3 [0:16383];

   int checks = 0;
   int failures = 0;

   always #5 HCLK = ~HCLK;

   ahbl_sram_ctrl #(.AHB_DWIDTH(32), .RAM_AWIDTH(14), .WAIT_STATES(0)) dut0 (
      .HCLK(HCLK), .HRESETN(HRESETN), .ahbsram_req(req0), .ahbsram_write(ahb_write),
      .ahbsram_wdata(ahb_wdata), .ahbsram_size(ahb_size), .ahbsram_addr(ahb_addr),
      .sramahb_ack(ack0), .sramahb_rdata(rdata0), .BUSY(busy0), .ram_addr(raddr0),
      .ram_wdata(rwdata0), .ram_ben(ben0), .ram_wen(wen0), .ram_ren(ren0),
      .ram_rdata(mrdata0));

   ahbl_sram_ctrl #(.AHB_DWIDTH(32), .RAM_AWIDTH(14), .WAIT_STATES(3)) dut3 (
      .HCLK(HCLK), .HRESETN(HRESETN), .ahbsram_req(req3), .ahbsram_write(ahb_write),
      .ahbsram_wdata(ahb_wdata), .ahbsram_size(ahb_size), .ahbsram_addr(ahb_addr),
      .sramahb_ack(ack3), .sramahb_rdata(rdata3), .BUSY(busy3), .ram_addr(raddr3),
      .ram_wdata(rwdata3), .ram_ben(ben3), .ram_wen(wen3), .ram_ren(ren3),
      .ram_rdata(mrdata3));

   // Behavioural SRAMs: byte-lane writes, registered read with one-cycle latency.
   always @(posedge HCLK) begin
      if (wen0) for (int b = 0; b < 4; b++) if (ben0[b]) mem0[raddr0][8*b +: 8] <= rwdata0[8*b +: 8];
      if (ren0) mrdata0 <= mem0[raddr0];
      if (wen3) for (int b = 0; b < 4; b++) if (ben3[b]) mem3[raddr3][8*b +: 8] <= rwdata3[8*b +: 8];
      if (ren3) mrdata3 <= mem3[raddr3];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One transaction on the selected instance. Checks strobe cycle, address,
   // lanes, data, BUSY every cycle, ack cycle and count, and read data at ack.
   // xreq>0 fires an extra request pulse in that cycle, which must be ignored.
   task automatic xact(input bit d3, input bit wr, input logic [19:0] a, input logic [2:0] sz,
                       input logic [31:0] wd, input logic [3:0] eben, input logic [13:0] eaddr,
                       input logic [31:0] erd, input int xreq, input string tag);
      int w, exp_strb, exp_ack, strb_c, strb_n, ack_c, ack_n;
      logic o_wen, o_ren, o_ack, o_busy;
      w = d3 ? 3 : 0;
      exp_strb = 1 + w;
      exp_ack = wr ? 2 + w : 3 + w;
      strb_c = 0; strb_n = 0; ack_c = 0; ack_n = 0;
      @(negedge HCLK);
      ahb_write = wr; ahb_addr = a; ahb_size = sz; ahb_wdata = wd;
      if (d3) req3 = 1'b1; else req0 = 1'b1;
      @(posedge HCLK);
      #1 req0 = 1'b0; req3 = 1'b0;
      for (int k = 1; k <= w + 5; k++) begin
         @(negedge HCLK);
         o_wen  = d3 ? wen3 : wen0;
         o_ren  = d3 ? ren3 : ren0;
         o_ack  = d3 ? ack3 : ack0;
         o_busy = d3 ? busy3 : busy0;
         if (o_wen || o_ren) begin
            strb_n++; strb_c = k;
            chk({tag, "_strb_kind"}, 32'({o_wen, o_ren}), 32'({wr, !wr}));
            chk({tag, "_ram_addr"}, 32'(d3 ? raddr3 : raddr0), 32'(eaddr));
            chk({tag, "_ram_ben"}, 32'(d3 ? ben3 : ben0), 32'(eben));
            if (wr) chk({tag, "_ram_wdata"}, d3 ? rwdata3 : rwdata0, wd);
         end
         chk($sformatf("%s_busy_c%0d", tag, k), 32'(o_busy), 32'(k <= exp_ack));
         if (o_ack) begin
            ack_n++; ack_c = k;
            if (!wr) chk({tag, "_rdata"}, d3 ? rdata3 : rdata0, erd);
         end
         if (k == xreq) begin
            if (d3) req3 = 1'b1; else req0 = 1'b1;
            @(posedge HCLK);
            #1 req0 = 1'b0; req3 = 1'b0;
         end
      end
      chk({tag, "_strb_cycle"}, 32'(strb_c), 32'(exp_strb));
      chk({tag, "_strb_count"}, 32'(strb_n), 32'd1);
      chk({tag, "_ack_cycle"}, 32'(ack_c), 32'(exp_ack));
      chk({tag, "_ack_count"}, 32'(ack_n), 32'd1);
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_ack"}, 32'(ack0), 32'd0);
      chk({tag, "_rdata"}, rdata0, 32'd0);
      chk({tag, "_busy"}, 32'(busy0), 32'd0);
      chk({tag, "_ram_addr"}, 32'(raddr0), 32'd0);
      chk({tag, "_ram_wdata"}, rwdata0, 32'd0);
      chk({tag, "_ram_ben"}, 32'(ben0), 32'd0);
      chk({tag, "_ram_wen"}, 32'(wen0), 32'd0);
      chk({tag, "_ram_ren"}, 32'(ren0), 32'd0);
      chk({tag, "_busy3"}, 32'(busy3), 32'd0);
   endtask

   initial begin
      int acks;
      #1 chk_reset_outs("por");
      repeat (3) @(negedge HCLK);
      HRESETN = 1'b1;

      // Word write/read, no wait states
      xact(0, 1, 20'h00010, 3'd2, 32'hDEADBEEF, 4'b1111, 14'd4, 32'h0, 0, "w_word");
      xact(0, 0, 20'h00010, 3'd2, 32'h0, 4'b1111, 14'd4, 32'hDEADBEEF, 0, "r_word");

      // Byte lanes
      xact(0, 1, 20'h00020, 3'd0, 32'h00000011, 4'b0001, 14'd8, 32'h0, 0, "w_b0");
      xact(0, 1, 20'h00021, 3'd0, 32'h00002200, 4'b0010, 14'd8, 32'h0, 0, "w_b1");
      xact(0, 1, 20'h00022, 3'd0, 32'h00330000, 4'b0100, 14'd8, 32'h0, 0, "w_b2");
      xact(0, 1, 20'h00023, 3'd0, 32'h44000000, 4'b1000, 14'd8, 32'h0, 0, "w_b3");
      xact(0, 0, 20'h00020, 3'd2, 32'h0, 4'b1111, 14'd8, 32'h44332211, 0, "r_bytes");

      // Halfword into upper half, lower half preserved; a request during ACK is ignored
      xact(0, 1, 20'h00030, 3'd2, 32'h12345678, 4'b1111, 14'd12, 32'h0, 0, "w_w30");
      xact(0, 1, 20'h00032, 3'd1, 32'hAAAA0000, 4'b1100, 14'd12, 32'h0, 2, "w_half");
      xact(0, 1, 20'h00031, 3'd1, 32'h0000BBBB, 4'b0011, 14'd12, 32'h0, 0, "w_half_lo");
      xact(0, 0, 20'h00030, 3'd2, 32'h0, 4'b1111, 14'd12, 32'hAAAABBBB, 0, "r_half");

      // Address wrap: bit 16 lies above the RAM and aliases onto word 4
      xact(0, 1, 20'h10010, 3'd2, 32'hCAFEF00D, 4'b1111, 14'd4, 32'h0, 0, "w_wrap");
      chk("rdata_kept_over_write", rdata0, 32'hAAAABBBB);
      xact(0, 0, 20'h00010, 3'd6, 32'h0, 4'b1111, 14'd4, 32'hCAFEF00D, 2, "r_wrap_rdcap_req");

      // Three wait states, extra request in WAIT and in RDCAP
      xact(1, 1, 20'h00040, 3'd2, 32'h5A5A5A5A, 4'b1111, 14'd16, 32'h0, 0, "w3_word");
      xact(1, 0, 20'h00040, 3'd2, 32'h0, 4'b1111, 14'd16, 32'h5A5A5A5A, 2, "r3_wait_req");
      xact(1, 0, 20'h00040, 3'd2, 32'h0, 4'b1111, 14'd16, 32'h5A5A5A5A, 5, "r3_rdcap_req");

      // Reset during RDCAP of a read
      @(negedge HCLK);
      ahb_write = 1'b0; ahb_addr = 20'h00020; ahb_size = 3'd2; req0 = 1'b1;
      @(posedge HCLK);
      #1 req0 = 1'b0;
      @(negedge HCLK);
      chk("rst_pre_ren", 32'(ren0), 32'd1);
      @(negedge HCLK);
      HRESETN = 1'b0;
      #1 chk_reset_outs("rst_mid");
      acks = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge HCLK);
         if (ack0) acks++;
      end
      chk("rst_no_ack", 32'(acks), 32'd0);
      HRESETN = 1'b1;
      xact(0, 0, 20'h00020, 3'd2, 32'h0, 4'b1111, 14'd8, 32'h44332211, 0, "r_after_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
